// File: rtl/fpga_bram_arbiter.sv
// Purpose : shares one BRAM port among NUM_REQ requesters (round-robin, bounded bursts)
//           and returns read data to the requester that issued the read.
// Latency : accept in cycle N -> bram_* driven in N+1 -> rsp_valid/rsp_rdata in N+1+READ_LATENCY.
// Backpressure: req_ready is one-hot or zero, combinational from req_valid and arbiter state;
//           read responses cannot be stalled.
// Ports   : clk/rst (async active-low); req_valid/req_ready/req_we/req_addr/req_wdata per
//           requester (packed); rsp_valid (one-hot) + shared rsp_rdata; bram_addra/dina/wea/ena
//           out, bram_douta/bram_error in; err_sticky latches bram_error until reset.
module fpga_bram_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 32,
    parameter int READ_LATENCY  = 2,
    parameter int MAX_BURST     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic [ADDRESS_WIDTH-1:0]           bram_addra,
    output logic [DATA_WIDTH-1:0]              bram_dina,
    output logic                               bram_wea,
    output logic                               bram_ena,
    input  logic [DATA_WIDTH-1:0]              bram_douta,
    input  logic                               bram_error,
    output logic                               err_sticky
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gnt_any;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   ptr_base;
    logic [IDW-1:0]   owner_nxt;
    logic [IDW:0]     pk;
    logic             rearb;
    logic [NUM_REQ-1:0] others;
    logic [IDW-1:0]   issue_id;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [IDW-1:0]          pipe_id [READ_LATENCY];

    // First valid requester at or after ptr, wrapping; returns {found, id}.
    function automatic logic [IDW:0] pick(input logic [NUM_REQ-1:0] v, input logic [IDW-1:0] ptr);
        logic           found;
        logic [IDW-1:0] id;
        int             idx;
        found = 1'b0;
        id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                id    = IDW'(idx);
            end
        end
        return {found, id};
    endfunction

    assign owner_nxt = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_any  = 1'b0;
        gnt_id   = owner_q;
        ptr_base = rr_ptr_q;
        rearb    = 1'b1;
        pk       = '0;
        others   = req_valid;
        others[owner_q] = 1'b0;

        if (state_q == BURST) begin
            if (req_valid[owner_q] && ((cnt_q < CW'(MAX_BURST)) || !(|others))) begin
                gnt_any = 1'b1;
                rearb   = 1'b0;
                if (cnt_q < CW'(MAX_BURST)) cnt_d = cnt_q + 1'b1;
            end else begin
                // Burst ends: advance the pointer and re-arbitrate in this same
                // cycle so the port sees no bubble between owners.
                ptr_base = owner_nxt;
                rr_ptr_d = owner_nxt;
            end
        end

        if (rearb) begin
            pk = pick(req_valid, ptr_base);
            if (pk[IDW]) begin
                gnt_any = 1'b1;
                gnt_id  = pk[IDW-1:0];
                state_d = BURST;
                owner_d = pk[IDW-1:0];
                cnt_d   = CW'(1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Gated by rst so every output reads zero while reset is held.
    assign req_ready = (rst && gnt_any) ? (NUM_REQ'(1) << gnt_id) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            issue_id   <= '0;
            err_sticky <= 1'b0;
        end else begin
            bram_ena <= gnt_any;
            bram_wea <= gnt_any & req_we[gnt_id];
            if (gnt_any) begin
                bram_addra <= req_addr[gnt_id*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                bram_dina  <= req_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
                issue_id   <= gnt_id;
            end
            if (bram_error) err_sticky <= 1'b1;
        end
    end

    // Tracks reads from the cycle ena is on the port; the last stage lines up with douta.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) pipe_id[k] <= '0;
        end else begin
            pipe_vld[0] <= bram_ena & ~bram_wea;
            pipe_id[0]  <= issue_id;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
            end
        end
    end

    assign rsp_valid = pipe_vld[READ_LATENCY-1] ? (NUM_REQ'(1) << pipe_id[READ_LATENCY-1]) : '0;
    assign rsp_rdata = pipe_vld[READ_LATENCY-1] ? bram_douta : '0;

endmodule

// File: tb/tb_fpga_bram_arbiter.sv
// Purpose : directed self-checking bench for fpga_bram_arbiter with a 2-cycle BRAM model.
// Latency : checks are cycle-exact where timing matters, queue-based for ordering.
// Backpressure: requesters hold valid until ready, as a real client would.
module tb_fpga_bram_arbiter;

    localparam int NR = 2;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int RL = 2;
    localparam int MB = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NR-1:0]       req_valid = '0;
    logic [NR-1:0]       req_ready;
    logic [NR-1:0]       req_we = '0;
    logic [NR*AW-1:0]    req_addr = '0;
    logic [NR*DW-1:0]    req_wdata = '0;
    logic [NR-1:0]       rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic [AW-1:0]       bram_addra;
    logic [DW-1:0]       bram_dina;
    logic                bram_wea;
    logic                bram_ena;
    logic [DW-1:0]       bram_douta;
    logic                bram_error = 1'b0;
    logic                err_sticky;

    int cmp  = 0;
    int errs = 0;

    fpga_bram_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .READ_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_ena(bram_ena), .bram_douta(bram_douta), .bram_error(bram_error),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // BRAM model: two register stages after ena.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] s1 = '0, s2 = '0;
    always @(posedge clk) begin
        if (bram_ena && bram_wea) mem[bram_addra[7:0]] <= bram_dina;
        if (bram_ena && !bram_wea) s1 <= mem[bram_addra[7:0]];
        s2 <= s1;
    end
    assign bram_douta = s2;

    // Response log.
    int            rsp_id_q [$];
    logic [DW-1:0] rsp_dat_q [$];
    always @(negedge clk) begin
        if (rst && (|rsp_valid)) begin
            for (int i = 0; i < NR; i++)
                if (rsp_valid[i]) rsp_id_q.push_back(i);
            rsp_dat_q.push_back(rsp_rdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 64'hA5A5;
        mem[8'h11] = 64'h1717;
        mem[8'h01] = 64'h1111;
        mem[8'h02] = 64'h2222;

        // Reset state
        ticks(2);
        chk("rst_ena", bram_ena, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_err", err_sticky, 0);
        rst = 1'b1;
        ticks(2);

        // T1 single read, cycle exact
        req_valid = 2'b01; req_we = 2'b00; req_addr[0 +: AW] = 32'h10;
        #1 chk("t1_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_ena", bram_ena, 1);
        chk("t1_addr", bram_addra, 32'h10);
        chk("t1_wea", bram_wea, 0);
        chk("t1_rsp_early", rsp_valid, 0);
        tick();
        chk("t1_ena_off", bram_ena, 0);
        chk("t1_rsp_early2", rsp_valid, 0);
        tick();
        chk("t1_rsp", rsp_valid, 2'b01);
        chk("t1_rdata", rsp_rdata, 64'hA5A5);
        tick();
        chk("t1_rsp_off", rsp_valid, 0);

        // T2 fairness: both valid, bursts of 4, no idle port cycles
        do_reset();
        rsp_id_q.delete(); rsp_dat_q.delete();
        req_valid = 2'b11; req_we = 2'b00;
        req_addr[0 +: AW] = 32'h10; req_addr[AW +: AW] = 32'h11;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("t2_gnt%0d", i), req_ready, 2'b01 << ((i / 4) % 2));
            if (i > 0) chk($sformatf("t2_ena%0d", i), bram_ena, 1);
            tick();
        end
        req_valid = 2'b00;
        ticks(6);
        chk("t2_rsp_cnt", rsp_id_q.size(), 12);
        if (rsp_id_q.size() == 12) begin
            chk("t2_rsp4_id", rsp_id_q[4], 1);
            chk("t2_rsp4_dat", rsp_dat_q[4], 64'h1717);
            chk("t2_rsp8_id", rsp_id_q[8], 0);
        end

        // T3 lone requester: no forced rotation past MAX_BURST
        rsp_id_q.delete(); rsp_dat_q.delete();
        req_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1 chk($sformatf("t3_gnt%0d", i), req_ready, 2'b10);
            tick();
        end
        req_valid = 2'b00;
        ticks(6);
        chk("t3_rsp_cnt", rsp_id_q.size(), 10);

        // T4 write then read same address
        rsp_id_q.delete(); rsp_dat_q.delete();
        req_valid = 2'b01; req_we = 2'b01;
        req_addr[0 +: AW] = 32'h20; req_wdata[0 +: DW] = 64'hDEAD;
        #1 chk("t4_wr_ready", req_ready, 2'b01);
        tick();
        chk("t4_wea", bram_wea, 1);
        chk("t4_dina", bram_dina, 64'hDEAD);
        req_we = 2'b00;
        #1 chk("t4_rd_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        ticks(6);
        chk("t4_rsp_cnt", rsp_id_q.size(), 1);
        if (rsp_id_q.size() == 1) begin
            chk("t4_rsp_id", rsp_id_q[0], 0);
            chk("t4_rsp_dat", rsp_dat_q[0], 64'hDEAD);
        end

        // T5 alternating single-beat reads from both requesters
        rsp_id_q.delete(); rsp_dat_q.delete();
        req_addr[0 +: AW] = 32'h1; req_addr[AW +: AW] = 32'h2;
        for (int i = 0; i < 6; i++) begin
            req_valid = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1 chk($sformatf("t5_gnt%0d", i), req_ready, req_valid);
            tick();
        end
        req_valid = 2'b00;
        ticks(6);
        chk("t5_rsp_cnt", rsp_id_q.size(), 6);
        if (rsp_id_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t5_id%0d", i), rsp_id_q[i], i % 2);
                chk($sformatf("t5_dat%0d", i), rsp_dat_q[i], (i % 2 == 0) ? 64'h1111 : 64'h2222);
            end
        end

        // Sticky error
        bram_error = 1'b1;
        tick();
        bram_error = 1'b0;
        chk("err_set", err_sticky, 1);
        ticks(2);
        chk("err_hold", err_sticky, 1);

        // T6 reset with two reads in flight
        rsp_id_q.delete(); rsp_dat_q.delete();
        req_valid = 2'b01; req_addr[0 +: AW] = 32'h10;
        ticks(2);
        chk("t6_inflight_ena", bram_ena, 1);
        rst = 1'b0;
        #1;
        chk("t6_ready", req_ready, 0);
        chk("t6_ena", bram_ena, 0);
        chk("t6_addr", bram_addra, 0);
        chk("t6_rsp", rsp_valid, 0);
        chk("t6_rdata", rsp_rdata, 0);
        chk("t6_err", err_sticky, 0);
        req_valid = 2'b00;
        ticks(2);
        rst = 1'b1;
        ticks(6);
        chk("t6_no_rsp", rsp_id_q.size(), 0);
        chk("t6_err_after", err_sticky, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
